// File: rtl/mnist_job_sequencer_if.sv
// mnist_job_sequencer_if
//   Bundles the datapath-facing signals of the job sequencer.
//   Layer control : o_LAYER_START, o_LAYER_SEL, o_IMG_IDX (to core), i_LAYER_DONE (from core)
//   Score stream  : i_SCORE_VALID, i_SCORE_DATA (from core), o_SCORE_READY (to core)
//   Output buffer : o_OUTBUF_WE, o_OUTBUF_ADDR, o_OUTBUF_DATA (to buffer write port)
//   master = sequencer side, slave = MLP core / output buffer side.
//   Index widths are clamped to at least 1 bit so single-image/single-layer
//   configurations stay legal.
interface mnist_job_sequencer_if #(
    parameter int IMGNUM = 10,
    parameter int NLAYER = 3,
    parameter int NCLASS = 10,
    parameter int FPW    = 32
);
    localparam int OAW = (IMGNUM * NCLASS > 1) ? $clog2(IMGNUM * NCLASS) : 1;
    localparam int LSW = (NLAYER > 1) ? $clog2(NLAYER) : 1;
    localparam int IW  = (IMGNUM > 1) ? $clog2(IMGNUM) : 1;

    logic           o_LAYER_START;
    logic [LSW-1:0] o_LAYER_SEL;
    logic [IW-1:0]  o_IMG_IDX;
    logic           i_LAYER_DONE;
    logic           i_SCORE_VALID;
    logic [FPW-1:0] i_SCORE_DATA;
    logic           o_SCORE_READY;
    logic           o_OUTBUF_WE;
    logic [OAW-1:0] o_OUTBUF_ADDR;
    logic [FPW-1:0] o_OUTBUF_DATA;

    modport master (
        output o_LAYER_START, o_LAYER_SEL, o_IMG_IDX, o_SCORE_READY,
               o_OUTBUF_WE, o_OUTBUF_ADDR, o_OUTBUF_DATA,
        input  i_LAYER_DONE, i_SCORE_VALID, i_SCORE_DATA
    );

    modport slave (
        input  o_LAYER_START, o_LAYER_SEL, o_IMG_IDX, o_SCORE_READY,
               o_OUTBUF_WE, o_OUTBUF_ADDR, o_OUTBUF_DATA,
        output i_LAYER_DONE, i_SCORE_VALID, i_SCORE_DATA
    );
endinterface

// File: rtl/mnist_job_sequencer.sv
// mnist_job_sequencer
//   Job sequencer for the DSDMNIST accelerator. A rising edge on i_START (in
//   IDLE) walks all IMGNUM images: per image one layer-start pulse per MLP
//   layer, then NCLASS scores are drained into the output buffer at a running
//   base address. Completion raises o_IRQ_DONE (1 cycle) and latches o_LED_DONE.
//   Ports:
//     i_CLK, i_RST (sync, active high), i_START (level, edge-triggered)
//     o_BUSY, o_IRQ_DONE, o_LED_DONE, o_CYCLES (job cycle count)
//     bus : mnist_job_sequencer_if.master (layer control, score stream, outbuf)
//   Optional feature macro: MNIST_SEQ_PERFCNT_EN enables the saturating busy
//   cycle counter on o_CYCLES; when undefined o_CYCLES is tied to 0.
//   All outputs are flops; decoded outputs are computed from the next state.
module mnist_job_sequencer #(
    parameter int IMGNUM = 10,
    parameter int NLAYER = 3,
    parameter int NCLASS = 10,
    parameter int FPW    = 32
) (
    input  logic        i_CLK,
    input  logic        i_RST,
    input  logic        i_START,
    output logic        o_BUSY,
    output logic        o_IRQ_DONE,
    output logic        o_LED_DONE,
    output logic [31:0] o_CYCLES,
    mnist_job_sequencer_if.master bus
);
    localparam int OAW = (IMGNUM * NCLASS > 1) ? $clog2(IMGNUM * NCLASS) : 1;
    localparam int LSW = (NLAYER > 1) ? $clog2(NLAYER) : 1;
    localparam int IW  = (IMGNUM > 1) ? $clog2(IMGNUM) : 1;
    localparam int KW  = (NCLASS > 1) ? $clog2(NCLASS) : 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LSTART  = 3'd1;
    localparam logic [2:0] S_LWAIT   = 3'd2;
    localparam logic [2:0] S_COLLECT = 3'd3;
    localparam logic [2:0] S_NEXT    = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    logic [2:0]     state_q, state_d;
    logic           start_q;
    logic [IW-1:0]  img_q, img_d;
    logic [LSW-1:0] layer_q, layer_d;
    logic [KW-1:0]  k_q, k_d;
    logic [OAW-1:0] base_q, base_d;
    logic           busy_q, busy_d;
    logic           irq_q, irq_d;
    logic           led_q, led_d;
    logic           lstart_q, lstart_d;
    logic           ready_q, ready_d;
    logic           we_q, we_d;
    logic [OAW-1:0] addr_q, addr_d;
    logic [FPW-1:0] data_q, data_d;
    logic           start_edge_s;
    logic           accept_s;

    assign start_edge_s = i_START & ~start_q;
    assign accept_s     = start_edge_s && (state_q == S_IDLE);

    // Next-state, counter and registered-output computation.
    always_comb begin
        state_d = state_q;
        img_d   = img_q;
        layer_d = layer_q;
        k_d     = k_q;
        base_d  = base_q;
        led_d   = led_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    state_d = S_LSTART;
                    img_d   = '0;
                    layer_d = '0;
                    base_d  = '0;
                    k_d     = '0;
                    led_d   = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LSTART: begin
                state_d = S_LWAIT;
            end
            S_LWAIT: begin
                if (bus.i_LAYER_DONE) begin
                    if (layer_q == LSW'(NLAYER - 1)) begin
                        k_d     = '0;
                        state_d = S_COLLECT;
                    end else begin
                        layer_d = layer_q + LSW'(1);
                        state_d = S_LSTART;
                    end
                end else begin
                    state_d = S_LWAIT;
                end
            end
            S_COLLECT: begin
                // ready_q is high exactly while in COLLECT, so valid alone
                // qualifies the handshake here.
                if (bus.i_SCORE_VALID && ready_q) begin
                    we_d   = 1'b1;
                    addr_d = base_q + OAW'(k_q);
                    data_d = bus.i_SCORE_DATA;
                    k_d    = k_q + KW'(1);
                    if (k_q == KW'(NCLASS - 1)) begin
                        state_d = S_NEXT;
                    end else begin
                        state_d = S_COLLECT;
                    end
                end else begin
                    state_d = S_COLLECT;
                end
            end
            S_NEXT: begin
                if (img_q == IW'(IMGNUM - 1)) begin
                    state_d = S_DONE;
                    led_d   = 1'b1;
                end else begin
                    img_d   = img_q + IW'(1);
                    layer_d = '0;
                    base_d  = base_q + OAW'(NCLASS);
                    state_d = S_LSTART;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d   = (state_d != S_IDLE);
        irq_d    = (state_d == S_DONE);
        lstart_d = (state_d == S_LSTART);
        ready_d  = (state_d == S_COLLECT);
    end

    // State, counters and output registers with synchronous reset.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state_q  <= S_IDLE;
            start_q  <= 1'b0;
            img_q    <= '0;
            layer_q  <= '0;
            k_q      <= '0;
            base_q   <= '0;
            busy_q   <= 1'b0;
            irq_q    <= 1'b0;
            led_q    <= 1'b0;
            lstart_q <= 1'b0;
            ready_q  <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            start_q  <= i_START;
            img_q    <= img_d;
            layer_q  <= layer_d;
            k_q      <= k_d;
            base_q   <= base_d;
            busy_q   <= busy_d;
            irq_q    <= irq_d;
            led_q    <= led_d;
            lstart_q <= lstart_d;
            ready_q  <= ready_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
        end
    end

`ifdef MNIST_SEQ_PERFCNT_EN
    logic [31:0] cycles_q, cycles_d;

    // Busy-cycle counter: cleared on an accepted start, saturating, holds in IDLE.
    always_comb begin
        if (accept_s) begin
            cycles_d = 32'd0;
        end else if (busy_q && (cycles_q != 32'hFFFF_FFFF)) begin
            cycles_d = cycles_q + 32'd1;
        end else begin
            cycles_d = cycles_q;
        end
    end

    // Busy-cycle counter register.
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            cycles_q <= 32'd0;
        end else begin
            cycles_q <= cycles_d;
        end
    end

    assign o_CYCLES = cycles_q;
`else
    assign o_CYCLES = 32'd0;
`endif

    assign o_BUSY            = busy_q;
    assign o_IRQ_DONE        = irq_q;
    assign o_LED_DONE        = led_q;
    assign bus.o_LAYER_START = lstart_q;
    assign bus.o_LAYER_SEL   = layer_q;
    assign bus.o_IMG_IDX     = img_q;
    assign bus.o_SCORE_READY = ready_q;
    assign bus.o_OUTBUF_WE   = we_q;
    assign bus.o_OUTBUF_ADDR = addr_q;
    assign bus.o_OUTBUF_DATA = data_q;
endmodule

// File: tb/tb_mnist_job_sequencer.sv
// tb_mnist_job_sequencer
//   dut_b (IMGNUM=1, NLAYER=1, NCLASS=2) is driven from a cycle table.
//   dut_a (defaults) is driven by an environment process (layer-done responder,
//   randomly gapped score producer) and checked by a write/layer monitor.
module tb_mnist_job_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, start_a, busy_a, irq_a, led_a;
    logic rst_b, start_b, busy_b, irq_b, led_b;
    logic [31:0] cyc_a, cyc_b;

    mnist_job_sequencer_if #(.IMGNUM(10), .NLAYER(3), .NCLASS(10), .FPW(32)) bus_a();
    mnist_job_sequencer_if #(.IMGNUM(1),  .NLAYER(1), .NCLASS(2),  .FPW(32)) bus_b();

    mnist_job_sequencer #(.IMGNUM(10), .NLAYER(3), .NCLASS(10), .FPW(32)) dut_a (
        .i_CLK(clk), .i_RST(rst_a), .i_START(start_a), .o_BUSY(busy_a),
        .o_IRQ_DONE(irq_a), .o_LED_DONE(led_a), .o_CYCLES(cyc_a), .bus(bus_a));
    mnist_job_sequencer #(.IMGNUM(1), .NLAYER(1), .NCLASS(2), .FPW(32)) dut_b (
        .i_CLK(clk), .i_RST(rst_b), .i_START(start_b), .o_BUSY(busy_b),
        .o_IRQ_DONE(irq_b), .o_LED_DONE(led_b), .o_CYCLES(cyc_b), .bus(bus_b));

    int n_pass = 0;
    int n_total = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endfunction

    function automatic logic [31:0] exp_cyc(logic [31:0] v);
`ifdef MNIST_SEQ_PERFCNT_EN
        return v;
`else
        return 32'd0;
`endif
    endfunction

    typedef struct {
        logic        start; logic ldone; logic valid; logic [31:0] data;
        logic        busy;  logic lstart; logic ready; logic we;
        logic [31:0] addr;  logic [31:0] wdata; logic irq; logic led; logic [31:0] cyc;
    } vec_t;
    vec_t tv[8];

    // dut_a environment and monitor state
    int  cd = 0;
    bit  hs_pend = 1'b0;
    int  sent = 0;
    bit  spur_en = 1'b0;
    int  ls_cnt = 0, wr_cnt = 0, irq_cnt = 0, busy_cnt = 0;

    // Environment: layer-done 4 cycles after each start, gapped score stream, spurious done.
    always @(negedge clk) begin
        if (hs_pend) sent++;
        bus_a.i_LAYER_DONE = 1'b0;
        if (cd > 0) begin
            cd--;
            if (cd == 0) bus_a.i_LAYER_DONE = 1'b1;
        end
        if (bus_a.o_LAYER_START) cd = 4;
        if (spur_en && (!busy_a || bus_a.o_LAYER_START ||
                        (bus_a.o_SCORE_READY && $urandom_range(0, 3) == 0)))
            bus_a.i_LAYER_DONE = 1'b1;
        if (bus_a.o_SCORE_READY && $urandom_range(0, 2) != 0) begin
            bus_a.i_SCORE_VALID = 1'b1;
            bus_a.i_SCORE_DATA  = 32'hA500_0000 | 32'(sent);
        end else begin
            bus_a.i_SCORE_VALID = 1'b0;
        end
        hs_pend = bus_a.i_SCORE_VALID && bus_a.o_SCORE_READY;
    end

    // Monitor: layer select/image order and in-order write stream of dut_a.
    always @(negedge clk) begin
        if (bus_a.o_LAYER_START) begin
            chk("layer_sel", 32'(bus_a.o_LAYER_SEL), 32'(ls_cnt % 3));
            chk("img_idx", 32'(bus_a.o_IMG_IDX), 32'(ls_cnt / 3));
            ls_cnt++;
        end
        if (bus_a.o_OUTBUF_WE) begin
            chk("wr_addr", 32'(bus_a.o_OUTBUF_ADDR), 32'(wr_cnt));
            chk("wr_data", bus_a.o_OUTBUF_DATA, 32'hA500_0000 | 32'(wr_cnt));
            wr_cnt++;
        end
        if (irq_a) irq_cnt++;
        if (busy_a) busy_cnt++;
    end

    // Starts a job on dut_a (call at a negedge); stops on IRQ or at the abort point.
    task automatic run_job(input int hold, input bit mid, input int abort_img);
        ls_cnt = 0; wr_cnt = 0; irq_cnt = 0; sent = 0; busy_cnt = 0;
        start_a = 1'b1;
        @(posedge clk); #1;
        chk("start_led_clr", 32'(led_a), 32'd0);
        chk("start_busy", 32'(busy_a), 32'd1);
        for (int c = 1; c < 5000; c++) begin
            @(negedge clk);
            if (c == hold) start_a = 1'b0;
            if (mid && c == hold + 20) start_a = 1'b1;
            if (mid && c == hold + 40) start_a = 1'b0;
            if (abort_img >= 0 && 32'(bus_a.o_IMG_IDX) == 32'(abort_img) && bus_a.o_SCORE_READY) break;
            if (irq_cnt != 0) break;
        end
        start_a = 1'b0;
    endtask

    task automatic check_job();
        chk("job_irq_seen", 32'(irq_cnt), 32'd1);
        repeat (20) @(negedge clk);
        chk("job_layer_starts", 32'(ls_cnt), 32'd30);
        chk("job_writes", 32'(wr_cnt), 32'd100);
        chk("job_irq_count", 32'(irq_cnt), 32'd1);
        chk("job_led", 32'(led_a), 32'd1);
        chk("job_idle", 32'(busy_a), 32'd0);
        chk("job_cycles", cyc_a, exp_cyc(32'(busy_cnt)));
    endtask

    int wr_hold;

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
        bus_a.i_LAYER_DONE = 1'b0; bus_a.i_SCORE_VALID = 1'b0; bus_a.i_SCORE_DATA = 32'd0;
        bus_b.i_LAYER_DONE = 1'b0; bus_b.i_SCORE_VALID = 1'b0; bus_b.i_SCORE_DATA = 32'd0;

        //            st   ld   vl   data            busy lst  rdy  we   addr   wdata          irq  led  cyc
        tv[0] = '{1'b1,1'b0,1'b0,32'h0,          1'b1,1'b1,1'b0,1'b0,32'd0,32'h0,          1'b0,1'b0,32'd0};
        tv[1] = '{1'b1,1'b0,1'b0,32'h0,          1'b1,1'b0,1'b0,1'b0,32'd0,32'h0,          1'b0,1'b0,32'd1};
        tv[2] = '{1'b1,1'b1,1'b0,32'h0,          1'b1,1'b0,1'b1,1'b0,32'd0,32'h0,          1'b0,1'b0,32'd2};
        tv[3] = '{1'b1,1'b0,1'b1,32'h3F80_0000,  1'b1,1'b0,1'b1,1'b1,32'd0,32'h3F80_0000,  1'b0,1'b0,32'd3};
        tv[4] = '{1'b1,1'b0,1'b1,32'h4000_0000,  1'b1,1'b0,1'b0,1'b1,32'd1,32'h4000_0000,  1'b0,1'b0,32'd4};
        tv[5] = '{1'b1,1'b0,1'b0,32'h0,          1'b1,1'b0,1'b0,1'b0,32'd1,32'h4000_0000,  1'b1,1'b1,32'd5};
        tv[6] = '{1'b1,1'b0,1'b0,32'h0,          1'b0,1'b0,1'b0,1'b0,32'd1,32'h4000_0000,  1'b0,1'b1,32'd6};
        tv[7] = '{1'b1,1'b0,1'b0,32'h0,          1'b0,1'b0,1'b0,1'b0,32'd1,32'h4000_0000,  1'b0,1'b1,32'd6};

        repeat (3) @(negedge clk);
        chk("rst_busy_a", 32'(busy_a), 32'd0);
        chk("rst_led_a", 32'(led_a), 32'd0);
        chk("rst_we_a", 32'(bus_a.o_OUTBUF_WE), 32'd0);
        chk("rst_cyc_a", cyc_a, 32'd0);
        chk("rst_busy_b", 32'(busy_b), 32'd0);
        rst_a = 1'b0; rst_b = 1'b0;
        @(negedge clk);

        // Scenario 1: small configuration, cycle by cycle.
        for (int i = 0; i < 8; i++) begin
            start_b = tv[i].start;
            bus_b.i_LAYER_DONE  = tv[i].ldone;
            bus_b.i_SCORE_VALID = tv[i].valid;
            bus_b.i_SCORE_DATA  = tv[i].data;
            @(posedge clk); #1;
            chk($sformatf("t%0d_busy", i),   32'(busy_b), 32'(tv[i].busy));
            chk($sformatf("t%0d_lstart", i), 32'(bus_b.o_LAYER_START), 32'(tv[i].lstart));
            chk($sformatf("t%0d_ready", i),  32'(bus_b.o_SCORE_READY), 32'(tv[i].ready));
            chk($sformatf("t%0d_we", i),     32'(bus_b.o_OUTBUF_WE), 32'(tv[i].we));
            chk($sformatf("t%0d_addr", i),   32'(bus_b.o_OUTBUF_ADDR), tv[i].addr);
            chk($sformatf("t%0d_wdata", i),  bus_b.o_OUTBUF_DATA, tv[i].wdata);
            chk($sformatf("t%0d_irq", i),    32'(irq_b), 32'(tv[i].irq));
            chk($sformatf("t%0d_led", i),    32'(led_b), 32'(tv[i].led));
            chk($sformatf("t%0d_cyc", i),    cyc_b, exp_cyc(tv[i].cyc));
            @(negedge clk);
        end

        // Spurious layer-done in IDLE on dut_b does nothing.
        start_b = 1'b0; bus_b.i_LAYER_DONE = 1'b1;
        @(posedge clk); #1;
        chk("b_idle_spur_busy", 32'(busy_b), 32'd0);
        @(negedge clk); bus_b.i_LAYER_DONE = 1'b0;

        // Start held high across reset release counts as one edge.
        start_b = 1'b1; rst_b = 1'b1;
        @(posedge clk); #1;
        chk("b_rst_busy", 32'(busy_b), 32'd0);
        chk("b_rst_led", 32'(led_b), 32'd0);
        @(negedge clk); rst_b = 1'b0;
        @(posedge clk); #1;
        chk("b_held_start_busy", 32'(busy_b), 32'd1);
        chk("b_held_start_lstart", 32'(bus_b.o_LAYER_START), 32'd1);
        @(negedge clk); rst_b = 1'b1; start_b = 1'b0;
        @(negedge clk); rst_b = 1'b0;

        // Scenario 2: default configuration, clean job.
        run_job(1, 1'b0, -1);
        check_job();

        // Scenario 3: start held 20 cycles plus a second edge mid-job.
        run_job(20, 1'b1, -1);
        check_job();

        // Scenario 4: spurious layer-done in IDLE, LSTART and COLLECT.
        spur_en = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_spur_busy", 32'(busy_a), 32'd0);
        run_job(1, 1'b0, -1);
        check_job();
        spur_en = 1'b0;
        repeat (5) @(negedge clk);

        // Scenario 5: reset during COLLECT of image 4, then a full job.
        run_job(1, 1'b0, 4);
        chk("abort_reached", 32'(bus_a.o_IMG_IDX), 32'd4);
        rst_a = 1'b1;
        @(posedge clk); #1;
        chk("abort_busy", 32'(busy_a), 32'd0);
        chk("abort_led", 32'(led_a), 32'd0);
        chk("abort_irq", 32'(irq_a), 32'd0);
        chk("abort_lstart", 32'(bus_a.o_LAYER_START), 32'd0);
        chk("abort_ready", 32'(bus_a.o_SCORE_READY), 32'd0);
        chk("abort_we", 32'(bus_a.o_OUTBUF_WE), 32'd0);
        chk("abort_addr", 32'(bus_a.o_OUTBUF_ADDR), 32'd0);
        chk("abort_data", bus_a.o_OUTBUF_DATA, 32'd0);
        chk("abort_img", 32'(bus_a.o_IMG_IDX), 32'd0);
        chk("abort_cyc", cyc_a, 32'd0);
        @(negedge clk); rst_a = 1'b0;
        wr_hold = wr_cnt;
        repeat (10) @(negedge clk);
        chk("abort_no_writes", 32'(wr_cnt), 32'(wr_hold));
        chk("abort_still_idle", 32'(busy_a), 32'd0);
        run_job(1, 1'b0, -1);
        check_job();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/mnist_job_sequencer.md
Name: mnist_job_sequencer

Overview:
- Top-level job sequencer for the DSDMNIST accelerator.
- On a start request it walks every image in the image ROM and, for each image, issues one start per MLP layer to the layer datapath, then drains the NCLASS class scores into the output buffer.
- When all images are done it raises the done IRQ and the done LED.
- Sits between the board start/IRQ/LED pins and the MLP core plus the output-buffer write port.

Parameters:
- IMGNUM, 10, number of images processed per job.
- NLAYER, 3, number of MLP layers per image.
- NCLASS, 10, class scores per image.
- FPW, 32, score word width (FP32).
- OAW, $clog2(IMGNUM*NCLASS), output-buffer address width (derived; not overridden).

Ports:
- i_CLK  in  1  system clock; all logic on rising edge.
- i_RST  in  1  synchronous, active-high reset.
- i_START  in  1  start request, level; a job starts on its rising edge.
- o_BUSY  out  1  high while a job is in progress.
- o_IRQ_DONE  out  1  one-cycle job-complete pulse.
- o_LED_DONE  out  1  latched done indicator.
- o_LAYER_START  out  1  one-cycle pulse that starts a layer in the MLP core.
- o_LAYER_SEL  out  $clog2(NLAYER)  index of the layer being started.
- o_IMG_IDX  out  $clog2(IMGNUM)  index of the current image.
- i_LAYER_DONE  in  1  one-cycle pulse from the MLP core: layer finished.
- i_SCORE_VALID  in  1  score stream valid.
- i_SCORE_DATA  in  FPW  score stream data.
- o_SCORE_READY  out  1  score stream ready.
- o_OUTBUF_WE  out  1  output-buffer write enable.
- o_OUTBUF_ADDR  out  OAW  output-buffer write address.
- o_OUTBUF_DATA  out  FPW  output-buffer write data.
- o_CYCLES  out  32  job cycle count (see Optional Feature).

Behaviour:
- Reset: i_RST high at a clock edge forces:
  - state to IDLE and all counters to 0;
  - the start edge register to 0;
  - every output to 0, including o_LED_DONE and o_CYCLES.
  - Reset mid-job abandons the job; no further writes or pulses occur.
- Start detection:
  - Edge = i_START & ~start_q, where start_q is i_START registered.
  - The edge is accepted only in IDLE; edges in any other state are ignored.
  - i_START held high across reset release counts as one edge.
  - A level held high after the edge never retriggers.
- IDLE: on an accepted edge, go to LSTART with img=0, layer=0, base address 0; clear o_LED_DONE.
- LSTART:
  - o_LAYER_START=1 for exactly this cycle; o_LAYER_SEL=layer; o_IMG_IDX=img.
  - Next state is LWAIT.
- LWAIT: waits for i_LAYER_DONE.
  - If layer<NLAYER-1: layer++ and go to LSTART.
  - Else: k=0 and go to COLLECT.
  - i_LAYER_DONE in any state other than LWAIT is ignored; it is not queued.
- COLLECT:
  - o_SCORE_READY=1 only in this state.
  - Each valid&ready handshake registers a write for the next cycle: o_OUTBUF_WE=1, o_OUTBUF_ADDR=base+k, o_OUTBUF_DATA=i_SCORE_DATA. Write latency is 1 cycle.
  - After each handshake, k++. The handshake with k==NCLASS-1 moves to NEXT.
  - Gaps in valid stall the state with no write.
  - The address uses a running base (base += NCLASS per image); no multiplier.
- NEXT:
  - If img==IMGNUM-1, go to DONE.
  - Else img++, layer=0, base+=NCLASS, go to LSTART.
- DONE: o_IRQ_DONE=1 for this single cycle; o_LED_DONE set (held until next accepted start or reset); go to IDLE.
- o_BUSY=1 in LSTART, LWAIT, COLLECT, NEXT, DONE; 0 in IDLE.
- o_OUTBUF_WE is 0 except the cycle after each score handshake. Address and data hold their last values when WE=0.
- The last address written is IMGNUM*NCLASS-1. No address outside 0..IMGNUM*NCLASS-1 is ever written.

Optional Feature:
- Macro: MNIST_SEQ_PERFCNT_EN.
- Defined:
  - o_CYCLES clears to 0 on an accepted start edge.
  - It increments by 1 every cycle o_BUSY=1 and saturates at 32'hFFFF_FFFF.
  - It holds its value in IDLE until the next accepted start.
- Undefined: o_CYCLES is constant 0 and no counter logic is synthesized.

Test Plan:
- Basic job, IMGNUM=1, NLAYER=1, NCLASS=2. Stimulus: start edge; bench asserts i_LAYER_DONE in the first LWAIT cycle; i_SCORE_VALID held high with data 32'h3F80_0000 then 32'h4000_0000. Required response:
  - writes addr0=3F800000, then addr1=40000000 on consecutive cycles;
  - exactly one o_IRQ_DONE pulse;
  - o_BUSY high 6 cycles;
  - o_CYCLES=6 with MNIST_SEQ_PERFCNT_EN defined.
- Defaults (10/3/10), with layer done 4 cycles after each start pulse and random valid gaps. Required response:
  - exactly 30 o_LAYER_START pulses with o_LAYER_SEL sequence 0,1,2 per image;
  - addresses 0..99 each written exactly once, in order;
  - one IRQ pulse; LED high afterwards.
- Start held high 20 cycles, and a second start edge issued mid-job. Required response:
  - only one job runs (30 layer starts total);
  - a start edge after DONE begins a new job, clears LED, and restarts writes at address 0.
- Spurious i_LAYER_DONE in IDLE, LSTART and COLLECT. Required response: no state advance and no extra layer start; write sequence identical to the clean run.
- i_RST pulsed for 1 cycle during COLLECT of image 4. Required response:
  - next cycle all outputs are 0, LED=0, no further writes;
  - a subsequent start completes a full 100-write job.
- With MNIST_SEQ_PERFCNT_EN undefined, rerun scenario 1. Required response: o_CYCLES=0 throughout; all other behaviour identical.
